// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NUM_REGS x DATA_W regfile; wr_* write port, two registered read ports rdN_en/addr -> rdN_data/valid/busy (write-first bypass), busy_set/busy_addr producer scoreboard
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  output logic              rd0_busy,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  output logic              rd1_busy,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr
);
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
  logic                rd0_valid_q, rd1_valid_q;
  logic                rd0_busy_q, rd0_busy_d, rd1_busy_q, rd1_busy_d;
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !(ZERO_REG && a == '0);
  endfunction
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en && ok(wr_addr)) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (busy_set && ok(busy_addr)) busy_d[busy_addr] = 1'b1;
    rd0_data_d = rd0_en ? (ok(rd0_addr) ? regs_d[rd0_addr] : '0) : rd0_data_q;
    rd0_busy_d = rd0_en ? (ok(rd0_addr) ? busy_d[rd0_addr] : 1'b0) : rd0_busy_q;
    rd1_data_d = rd1_en ? (ok(rd1_addr) ? regs_d[rd1_addr] : '0) : rd1_data_q;
    rd1_busy_d = rd1_en ? (ok(rd1_addr) ? busy_d[rd1_addr] : 1'b0) : rd1_busy_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '{default: '0};
      busy_q      <= '0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd0_busy_q  <= 1'b0;
      rd1_busy_q  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
      rd0_valid_q <= rd0_en;
      rd1_valid_q <= rd1_en;
      rd0_busy_q  <= rd0_busy_d;
      rd1_busy_q  <= rd1_busy_d;
    end
  end
  assign rd0_data  = rd0_data_q;
  assign rd0_valid = rd0_valid_q;
  assign rd0_busy  = rd0_busy_q;
  assign rd1_data  = rd1_data_q;
  assign rd1_valid = rd1_valid_q;
  assign rd1_busy  = rd1_busy_q;
endmodule
